// File: rtl/multicycle_mem_port.sv
// Memory-access sequencer: turns one control-path request into one
// byte-lane-aligned bus cycle with a ready handshake, and returns extended load data.
// Optional MEM_PORT_TIMEOUT_EN adds an ACCESS watchdog that reports bus_error.
module multicycle_mem_port #(
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        req_valid,
    input  logic        req_write,
    input  logic [31:0] req_addr,
    input  logic [2:0]  req_funct3,
    input  logic [31:0] req_wdata,
    output logic        stall,
    output logic        resp_valid,
    output logic [31:0] rdata,
    output logic        misaligned,
    output logic        bus_error,
    output logic [31:0] bus_addr,
    output logic [31:0] bus_wdata,
    output logic [3:0]  bus_byte_enable,
    output logic        bus_read_enable,
    output logic        bus_write_enable,
    input  logic        bus_ready,
    input  logic [31:0] bus_rdata
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        DONE   = 2'd2
    } state_t;

    state_t      state;
    logic        write_q;
    logic [2:0]  funct3_q;
    logic [1:0]  lane_q;

    logic        req_is_b;
    logic        req_is_h;
    logic        req_misaligned;
    logic [3:0]  req_be;
    logic [31:0] req_lane_wdata;

    logic        ld_is_b;
    logic        ld_is_h;
    logic [31:0] ld_shifted;
    logic [31:0] ld_value;

`ifdef MEM_PORT_TIMEOUT_EN
    localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
    logic [CW-1:0] wait_cnt;
    logic          err_q;
    assign bus_error = err_q;
`else
    logic unused_timeout_cfg;
    assign unused_timeout_cfg = (TIMEOUT_CYCLES >= 1);
    assign bus_error = 1'b0;
`endif

    assign stall = ((state == IDLE) && req_valid) || (state == ACCESS);

    // Decode request size into alignment check, byte lanes and replicated store data
    always_comb begin
        req_is_b       = (req_funct3 == 3'b000) || (req_funct3 == 3'b100);
        req_is_h       = (req_funct3 == 3'b001) || (req_funct3 == 3'b101);
        req_misaligned = 1'b0;
        req_be         = 4'b1111;
        req_lane_wdata = req_wdata;
        if (req_is_b) begin
            req_be         = 4'b0001 << req_addr[1:0];
            req_lane_wdata = {4{req_wdata[7:0]}};
        end else if (req_is_h) begin
            req_misaligned = req_addr[0];
            req_be         = 4'b0011 << req_addr[1:0];
            req_lane_wdata = {2{req_wdata[15:0]}};
        end else begin
            req_misaligned = (req_addr[1:0] != 2'b00);
        end
    end

    // Pick the addressed lane of the returned word and extend it
    always_comb begin
        ld_is_b    = (funct3_q == 3'b000) || (funct3_q == 3'b100);
        ld_is_h    = (funct3_q == 3'b001) || (funct3_q == 3'b101);
        ld_shifted = bus_rdata >> {lane_q, 3'b000};
        ld_value   = bus_rdata;
        if (ld_is_b) begin
            ld_value = {{24{ld_shifted[7] & ~funct3_q[2]}}, ld_shifted[7:0]};
        end else if (ld_is_h) begin
            ld_value = {{16{ld_shifted[15] & ~funct3_q[2]}}, ld_shifted[15:0]};
        end
    end

    // Sequencer FSM with registered bus and response outputs
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state            <= IDLE;
            write_q          <= 1'b0;
            funct3_q         <= 3'b000;
            lane_q           <= 2'b00;
            resp_valid       <= 1'b0;
            misaligned       <= 1'b0;
            rdata            <= 32'h0;
            bus_addr         <= 32'h0;
            bus_wdata        <= 32'h0;
            bus_byte_enable  <= 4'h0;
            bus_read_enable  <= 1'b0;
            bus_write_enable <= 1'b0;
`ifdef MEM_PORT_TIMEOUT_EN
            wait_cnt         <= '0;
            err_q            <= 1'b0;
`endif
        end else begin
            resp_valid <= 1'b0;
            misaligned <= 1'b0;
`ifdef MEM_PORT_TIMEOUT_EN
            err_q      <= 1'b0;
`endif
            unique case (state)
                IDLE: begin
                    if (req_valid) begin
                        write_q  <= req_write;
                        funct3_q <= req_funct3;
                        lane_q   <= req_addr[1:0];
                        if (req_misaligned) begin
                            state      <= DONE;
                            resp_valid <= 1'b1;
                            misaligned <= 1'b1;
                            rdata      <= 32'h0;
                        end else begin
                            state            <= ACCESS;
                            bus_addr         <= {req_addr[31:2], 2'b00};
                            bus_wdata        <= req_lane_wdata;
                            bus_byte_enable  <= req_be;
                            bus_read_enable  <= ~req_write;
                            bus_write_enable <= req_write;
`ifdef MEM_PORT_TIMEOUT_EN
                            wait_cnt         <= '0;
`endif
                        end
                    end
                end
                ACCESS: begin
                    if (bus_ready) begin
                        if (!write_q) begin
                            rdata <= ld_value;
                        end
                        state            <= DONE;
                        resp_valid       <= 1'b1;
                        bus_byte_enable  <= 4'h0;
                        bus_read_enable  <= 1'b0;
                        bus_write_enable <= 1'b0;
                    end
`ifdef MEM_PORT_TIMEOUT_EN
                    else if (wait_cnt == CW'(TIMEOUT_CYCLES - 1)) begin
                        state            <= DONE;
                        resp_valid       <= 1'b1;
                        err_q            <= 1'b1;
                        rdata            <= 32'h0;
                        bus_byte_enable  <= 4'h0;
                        bus_read_enable  <= 1'b0;
                        bus_write_enable <= 1'b0;
                    end else begin
                        wait_cnt <= wait_cnt + 1'b1;
                    end
`endif
                end
                DONE: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_multicycle_mem_port.sv
// Bench for multicycle_mem_port: directed and random accesses against
// a behavioural model of lanes, extension and latency.
module tb_multicycle_mem_port;

    localparam int TO = 4;

    logic        clock = 1'b0;
    logic        reset;
    logic        req_valid;
    logic        req_write;
    logic [31:0] req_addr;
    logic [2:0]  req_funct3;
    logic [31:0] req_wdata;
    logic        stall;
    logic        resp_valid;
    logic [31:0] rdata;
    logic        misaligned;
    logic        bus_error;
    logic [31:0] bus_addr;
    logic [31:0] bus_wdata;
    logic [3:0]  bus_byte_enable;
    logic        bus_read_enable;
    logic        bus_write_enable;
    logic        bus_ready;
    logic [31:0] bus_rdata;

    int checks = 0;
    int failures = 0;
    logic [31:0] model_rdata = 32'h0;

    multicycle_mem_port #(.TIMEOUT_CYCLES(TO)) dut (
        .clock(clock),
        .reset(reset),
        .req_valid(req_valid),
        .req_write(req_write),
        .req_addr(req_addr),
        .req_funct3(req_funct3),
        .req_wdata(req_wdata),
        .stall(stall),
        .resp_valid(resp_valid),
        .rdata(rdata),
        .misaligned(misaligned),
        .bus_error(bus_error),
        .bus_addr(bus_addr),
        .bus_wdata(bus_wdata),
        .bus_byte_enable(bus_byte_enable),
        .bus_read_enable(bus_read_enable),
        .bus_write_enable(bus_write_enable),
        .bus_ready(bus_ready),
        .bus_rdata(bus_rdata)
    );

    always #5 clock = ~clock;

    function automatic int size_of(input logic [2:0] f3);
        if (f3[1:0] == 2'd0) return 1;
        if (f3[1:0] == 2'd1) return 2;
        return 4;
    endfunction

    function automatic logic [3:0] exp_be(input logic [31:0] a, input logic [2:0] f3);
        logic [7:0] m;
        int s;
        s = size_of(f3);
        m = 8'(((1 << s) - 1) << (a % 4));
        if (s == 4) return 4'hF;
        return m[3:0];
    endfunction

    function automatic logic [31:0] exp_wd(input logic [31:0] d, input logic [2:0] f3);
        int s;
        s = size_of(f3);
        if (s == 1) return {24'h0, d[7:0]} * 32'h0101_0101;
        if (s == 2) return {16'h0, d[15:0]} * 32'h0001_0001;
        return d;
    endfunction

    function automatic logic [31:0] exp_ld(input logic [31:0] w, input logic [31:0] a,
                                          input logic [2:0] f3);
        logic [31:0] v;
        int s;
        s = size_of(f3);
        v = w >> (8 * (a % 4));
        if (s == 1) begin
            v = v & 32'hFF;
            if (!f3[2] && v >= 32'h80) v = v | 32'hFFFF_FF00;
        end else if (s == 2) begin
            v = v & 32'hFFFF;
            if (!f3[2] && v >= 32'h8000) v = v | 32'hFFFF_0000;
        end
        return v;
    endfunction

    // One complete access; waits < 0 means the bus never answers.
    task automatic do_access(input logic wr, input logic [31:0] a, input logic [2:0] f3,
                             input logic [31:0] wd, input int waits, input logic [31:0] word,
                             input string name);
        logic mis;
        logic tout;
        int lat;
        int c;
        bit got;
        mis = (a % size_of(f3)) != 0;
`ifdef MEM_PORT_TIMEOUT_EN
        tout = !mis && (waits < 0 || waits >= TO);
`else
        tout = 1'b0;
`endif
        lat = mis ? 1 : (tout ? TO + 1 : waits + 2);
        @(posedge clock); #1;
        req_valid = 1'b1; req_write = wr; req_addr = a;
        req_funct3 = f3; req_wdata = wd; bus_ready = 1'b0;
        #1;
        checks++;
        if (stall !== 1'b1 || resp_valid !== 1'b0 || misaligned !== 1'b0 || bus_error !== 1'b0) begin
            failures++;
            $display("FAIL %s req cycle: stall=%b resp=%b mis=%b err=%b want 1 0 0 0",
                     name, stall, resp_valid, misaligned, bus_error);
        end
        c = 0; got = 0;
        while (!got && c <= lat + 2) begin
            @(posedge clock); #1;
            c++;
            bus_ready = 1'b0;
            bus_rdata = $urandom;
            if (resp_valid === 1'b1) begin
                got = 1;
                if (mis) model_rdata = 32'h0;
                else if (tout) model_rdata = 32'h0;
                else if (!wr) model_rdata = exp_ld(word, a, f3);
                #1;
                checks++;
                if (c != lat || misaligned !== mis || bus_error !== tout || rdata !== model_rdata
                    || stall !== 1'b0) begin
                    failures++;
                    $display("FAIL %s resp: cyc=%0d mis=%b err=%b rdata=%h stall=%b want %0d %b %b %h 0",
                             name, c, misaligned, bus_error, rdata, stall, lat, mis, tout, model_rdata);
                end
                checks++;
                if (bus_read_enable !== 1'b0 || bus_write_enable !== 1'b0 || bus_byte_enable !== 4'h0) begin
                    failures++;
                    $display("FAIL %s done enables: rd=%b wr=%b be=%h want 0 0 0",
                             name, bus_read_enable, bus_write_enable, bus_byte_enable);
                end
                bus_ready = 1'($urandom);
            end else if (!mis && c < lat) begin
                checks++;
                if (bus_addr !== {a[31:2], 2'b00} || bus_byte_enable !== exp_be(a, f3)
                    || bus_read_enable !== !wr || bus_write_enable !== wr || stall !== 1'b1
                    || (wr && bus_wdata !== exp_wd(wd, f3))) begin
                    failures++;
                    $display("FAIL %s bus cyc %0d: addr=%h be=%h rd=%b wr=%b wd=%h stall=%b want %h %h %b %b %h 1",
                             name, c, bus_addr, bus_byte_enable, bus_read_enable, bus_write_enable,
                             bus_wdata, stall, {a[31:2], 2'b00}, exp_be(a, f3), !wr, wr,
                             exp_wd(wd, f3));
                end
                if (!tout && c == waits + 1) begin
                    bus_ready = 1'b1;
                    bus_rdata = word;
                end
            end else begin
                checks++;
                if (bus_read_enable !== 1'b0 || bus_write_enable !== 1'b0) begin
                    failures++;
                    $display("FAIL %s stray enable cyc %0d: rd=%b wr=%b",
                             name, c, bus_read_enable, bus_write_enable);
                end
            end
        end
        if (!got) begin
            checks++;
            failures++;
            $display("FAIL %s no resp_valid within %0d cycles (want %0d)", name, c, lat);
        end
    endtask

    task automatic idle_cycles(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clock); #1;
            req_valid = 1'b0;
            bus_ready = 1'($urandom);
        end
    endtask

    task automatic test_reset;
        reset = 1'b1; req_valid = 1'b0; req_write = 1'b0; req_addr = 32'h0;
        req_funct3 = 3'b010; req_wdata = 32'h0; bus_ready = 1'b0; bus_rdata = 32'h0;
        repeat (2) @(posedge clock);
        #1;
        checks++;
        if (resp_valid !== 0 || rdata !== 0 || misaligned !== 0 || bus_error !== 0
            || bus_addr !== 0 || bus_wdata !== 0 || bus_byte_enable !== 0
            || bus_read_enable !== 0 || bus_write_enable !== 0 || stall !== 0) begin
            failures++;
            $display("FAIL reset_state: resp=%b rdata=%h be=%h addr=%h stall=%b want all 0",
                     resp_valid, rdata, bus_byte_enable, bus_addr, stall);
        end
        @(negedge clock);
        reset = 1'b0;
        model_rdata = 32'h0;
    endtask

    task automatic test_directed;
        do_access(1'b0, 32'h100, 3'b010, 32'h0, 3, 32'hDEAD_BEEF, "lw_wait3");
        do_access(1'b0, 32'h203, 3'b000, 32'h0, 0, 32'h8012_3456, "lb_sext");
        do_access(1'b0, 32'h203, 3'b100, 32'h0, 1, 32'h8012_3456, "lbu_zext");
        do_access(1'b0, 32'h202, 3'b101, 32'h0, 0, 32'hBEEF_1234, "lhu_hi");
        do_access(1'b1, 32'h402, 3'b001, 32'h1234_ABCD, 2, 32'h0, "sh_lane");
        do_access(1'b0, 32'h101, 3'b010, 32'h0, 0, 32'h0, "lw_misaligned");
        do_access(1'b0, 32'h103, 3'b101, 32'h0, 0, 32'h0, "lhu_misaligned");
        do_access(1'b1, 32'h501, 3'b000, 32'hA5, 0, 32'h0, "sb_lane1");
        idle_cycles(2);
    endtask

    task automatic test_reset_mid_access;
        do_access(1'b0, 32'h0000_0040, 3'b010, 32'h0, 0, 32'h1111_2222, "pre_reset");
        @(posedge clock); #1;
        req_valid = 1'b1; req_write = 1'b0; req_addr = 32'h300; req_funct3 = 3'b010;
        bus_ready = 1'b0;
        @(posedge clock); #1;
        checks++;
        if (bus_read_enable !== 1'b1) begin
            failures++;
            $display("FAIL mid_reset setup: rd=%b want 1", bus_read_enable);
        end
        #2;
        reset = 1'b1;
        #1;
        checks++;
        if (bus_read_enable !== 0 || bus_byte_enable !== 0 || bus_addr !== 0 || stall !== 1'b1
            || rdata !== 0) begin
            failures++;
            $display("FAIL mid_reset async: rd=%b be=%h addr=%h stall=%b rdata=%h want 0 0 0 1 0",
                     bus_read_enable, bus_byte_enable, bus_addr, stall, rdata);
        end
        req_valid = 1'b0;
        #1;
        checks++;
        if (stall !== 1'b0 || resp_valid !== 1'b0) begin
            failures++;
            $display("FAIL mid_reset idle: stall=%b resp=%b want 0 0", stall, resp_valid);
        end
        @(negedge clock);
        reset = 1'b0;
        model_rdata = 32'h0;
        do_access(1'b0, 32'h304, 3'b010, 32'h0, 1, 32'hCAFE_F00D, "post_reset");
    endtask

    task automatic test_long_wait;
`ifdef MEM_PORT_TIMEOUT_EN
        do_access(1'b0, 32'h600, 3'b010, 32'h0, -1, 32'h0, "timeout_err");
        do_access(1'b1, 32'h604, 3'b010, 32'h5555_AAAA, -1, 32'h0, "timeout_store");
        do_access(1'b0, 32'h608, 3'b010, 32'h0, TO - 1, 32'h7777_8888, "ready_at_limit");
`else
        do_access(1'b0, 32'h600, 3'b010, 32'h0, 30, 32'h7777_8888, "long_wait");
`endif
    endtask

    task automatic test_back_to_back_random;
        logic [2:0] f3s [8];
        logic [31:0] a;
        logic [2:0] f3;
        f3s = '{3'b000, 3'b001, 3'b010, 3'b100, 3'b101, 3'b011, 3'b110, 3'b111};
        for (int i = 0; i < 60; i++) begin
            f3 = f3s[$urandom_range(0, 7)];
            a = $urandom;
            if ($urandom_range(0, 3) != 0) a = a & ~(32'(size_of(f3)) - 1);
            do_access(1'($urandom), a, f3, $urandom, $urandom_range(0, 3), $urandom, "random");
            if ($urandom_range(0, 2) == 0) idle_cycles($urandom_range(1, 2));
        end
    endtask

    initial begin
        test_reset;
        test_directed;
        test_reset_mid_access;
        test_long_wait;
        test_back_to_back_random;
        idle_cycles(2);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
